// File: rtl/button_event_ctrl.sv
// Per-button press/long/repeat/release event scheduler feeding one valid/ready event channel.
// Optional macro BTN_EVT_RR_ARB_EN selects round-robin button arbitration (default: lowest index wins).
module button_event_ctrl #(
    parameter int unsigned N_BTN      = 4,
    parameter int unsigned LONG_CYC   = 50000000,
    parameter int unsigned REPEAT_CYC = 10000000,
    localparam int unsigned ID_W      = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk_core,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_i,
    input  logic             evt_ready_i,
    output logic             evt_valid_o,
    output logic [ID_W-1:0]  evt_id_o,
    output logic [1:0]       evt_type_o,
    output logic [N_BTN-1:0] ovf_o,
    input  logic             ovf_clr_i,
    output logic             busy_o
);

    localparam int unsigned MAX_CYC = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [1:0] EVT_PRESS   = 2'd0;
    localparam logic [1:0] EVT_RELEASE = 2'd1;
    localparam logic [1:0] EVT_LONG    = 2'd2;
    localparam logic [1:0] EVT_REPEAT  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DOWN = 2'd1,
        HOLD = 2'd2
    } st_t;

    logic [N_BTN-1:0] btn_q;
    st_t              st_q    [N_BTN];
    st_t              st_d    [N_BTN];
    logic [CNT_W-1:0] cnt_q   [N_BTN];
    logic [CNT_W-1:0] cnt_d   [N_BTN];
    logic [3:0]       raise   [N_BTN];
    logic [3:0]       pend_q  [N_BTN];
    logic [3:0]       pend_d  [N_BTN];
    logic [3:0]       consume [N_BTN];

    logic             load;
    logic             found;
    logic [ID_W-1:0]  sel_id;
    logic [3:0]       sel_pend;
    logic [1:0]       sel_type;
    logic [N_BTN-1:0] ovf_set;
    logic [N_BTN-1:0] ovf_d;
    logic             valid_d;
    logic [ID_W-1:0]  id_d;
    logic [1:0]       type_d;
    logic             busy_d;

`ifdef BTN_EVT_RR_ARB_EN
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  rr_ptr_d;
`endif

    // Per-button FSM: release always beats LONG/REPEAT on the same edge.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            raise[i] = 4'b0000;
            case (st_q[i])
                IDLE: begin
                    if (btn_i[i] && !btn_q[i]) begin
                        raise[i][EVT_PRESS] = 1'b1;
                        cnt_d[i]            = '0;
                        st_d[i]             = DOWN;
                    end
                end
                DOWN: begin
                    if (!btn_i[i]) begin
                        raise[i][EVT_RELEASE] = 1'b1;
                        st_d[i]               = IDLE;
                    end else if (cnt_q[i] == CNT_W'(LONG_CYC - 1)) begin
                        raise[i][EVT_LONG] = 1'b1;
                        cnt_d[i]           = '0;
                        st_d[i]            = HOLD;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (!btn_i[i]) begin
                        raise[i][EVT_RELEASE] = 1'b1;
                        st_d[i]               = IDLE;
                    end else if (cnt_q[i] == CNT_W'(REPEAT_CYC - 1)) begin
                        raise[i][EVT_REPEAT] = 1'b1;
                        cnt_d[i]             = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    st_d[i] = IDLE;
                end
            endcase
        end
    end

    // Arbitration, pending-bit bookkeeping and output register next state.
    always_comb begin
        load     = !evt_valid_o || evt_ready_i;
        found    = 1'b0;
        sel_id   = '0;
        sel_pend = 4'b0000;
        sel_type = EVT_PRESS;
        valid_d  = evt_valid_o;
        id_d     = evt_id_o;
        type_d   = evt_type_o;
        ovf_set  = '0;
`ifdef BTN_EVT_RR_ARB_EN
        rr_ptr_d = rr_ptr;
        // First pass covers indices after the last grant; second pass wraps around.
        for (int i = 0; i < N_BTN; i++) begin
            if (!found && (|pend_q[i]) && (ID_W'(i) > rr_ptr)) begin
                found  = 1'b1;
                sel_id = ID_W'(i);
            end
        end
`endif
        for (int i = 0; i < N_BTN; i++) begin
            if (!found && (|pend_q[i])) begin
                found  = 1'b1;
                sel_id = ID_W'(i);
            end
        end
        for (int i = 0; i < N_BTN; i++) begin
            if (ID_W'(i) == sel_id) begin
                sel_pend = pend_q[i];
            end
        end

        if (sel_pend[EVT_PRESS]) begin
            sel_type = EVT_PRESS;
        end else if (sel_pend[EVT_LONG]) begin
            sel_type = EVT_LONG;
        end else if (sel_pend[EVT_REPEAT]) begin
            sel_type = EVT_REPEAT;
        end else begin
            sel_type = EVT_RELEASE;
        end

        if (load) begin
            valid_d = found;
            if (found) begin
                id_d   = sel_id;
                type_d = sel_type;
`ifdef BTN_EVT_RR_ARB_EN
                rr_ptr_d = sel_id;
`endif
            end
        end

        // A raise onto a bit consumed this cycle re-arms it without counting as lost.
        for (int i = 0; i < N_BTN; i++) begin
            consume[i] = (load && found && (sel_id == ID_W'(i))) ? (4'b0001 << sel_type) : 4'b0000;
            pend_d[i]  = (pend_q[i] & ~consume[i]) | raise[i];
            ovf_set[i] = |(raise[i] & pend_q[i] & ~consume[i]);
        end

        ovf_d  = (ovf_clr_i ? '0 : ovf_o) | ovf_set;
        busy_d = valid_d;
        for (int i = 0; i < N_BTN; i++) begin
            busy_d = busy_d | (|pend_d[i]);
        end
    end

    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            btn_q       <= '0;
            evt_valid_o <= 1'b0;
            evt_id_o    <= '0;
            evt_type_o  <= 2'd0;
            ovf_o       <= '0;
            busy_o      <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                st_q[i]   <= IDLE;
                cnt_q[i]  <= '0;
                pend_q[i] <= 4'b0000;
            end
        end else begin
            btn_q       <= btn_i;
            evt_valid_o <= valid_d;
            evt_id_o    <= id_d;
            evt_type_o  <= type_d;
            ovf_o       <= ovf_d;
            busy_o      <= busy_d;
            for (int i = 0; i < N_BTN; i++) begin
                st_q[i]   <= st_d[i];
                cnt_q[i]  <= cnt_d[i];
                pend_q[i] <= pend_d[i];
            end
        end
    end

`ifdef BTN_EVT_RR_ARB_EN
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_ptr_d;
        end
    end
`endif

endmodule

// File: tb/tb_button_event_ctrl.sv
// Scoreboard bench for button_event_ctrl: a hold-time based event model feeds an expected-event queue.
module tb_button_event_ctrl;

    localparam int N  = 4;
    localparam int LC = 8;
    localparam int RC = 4;

    logic         clk_core = 1'b0;
    logic         rst_n    = 1'b1;
    logic [N-1:0] btn      = '0;
    logic         ready    = 1'b1;
    logic         clr      = 1'b0;
    logic         evt_valid;
    logic [1:0]   evt_id;
    logic [1:0]   evt_type;
    logic [N-1:0] ovf;
    logic         busy;

    always #5 clk_core = ~clk_core;

    button_event_ctrl #(
        .N_BTN      (N),
        .LONG_CYC   (LC),
        .REPEAT_CYC (RC)
    ) dut (
        .clk_core    (clk_core),
        .rst_n       (rst_n),
        .btn_i       (btn),
        .evt_ready_i (ready),
        .evt_valid_o (evt_valid),
        .evt_id_o    (evt_id),
        .evt_type_o  (evt_type),
        .ovf_o       (ovf),
        .ovf_clr_i   (clr),
        .busy_o      (busy)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [1:0] typ;
    } evt_t;

    int   checks   = 0;
    int   failures = 0;
    evt_t exp_q[$];

    // Reference model state: hold time per button, abstract pending sets, presented event.
    logic [N-1:0] m_prev;
    int           m_hold [N];
    logic [3:0]   m_pend [N];
    logic         m_valid;
    logic [1:0]   m_id;
    logic [1:0]   m_type;
    logic [N-1:0] m_ovf;
    logic         m_busy;
    int           m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev  = '0;
        m_valid = 1'b0;
        m_id    = 2'd0;
        m_type  = 2'd0;
        m_ovf   = '0;
        m_busy  = 1'b0;
        m_last  = 0;
        for (int i = 0; i < N; i++) begin
            m_hold[i] = 0;
            m_pend[i] = 4'b0000;
        end
        exp_q.delete();
    endtask

    task automatic model_step();
        logic [3:0]   rs [N];
        logic [N-1:0] set_ovf;
        logic [3:0]   p;
        logic [1:0]   gt;
        logic         ld;
        logic         found;
        int           gid;
        evt_t         e;
        ld = !m_valid || ready;
        // Events follow from how long each button has been seen high.
        for (int i = 0; i < N; i++) begin
            rs[i] = 4'b0000;
            if (btn[i] && !m_prev[i]) begin
                rs[i][0]  = 1'b1;
                m_hold[i] = 1;
            end else if (!btn[i] && m_prev[i]) begin
                rs[i][1]  = 1'b1;
                m_hold[i] = 0;
            end else if (btn[i]) begin
                m_hold[i]++;
                if (m_hold[i] == LC + 1) rs[i][2] = 1'b1;
                else if (m_hold[i] > LC + 1 && ((m_hold[i] - 1 - LC) % RC) == 0) rs[i][3] = 1'b1;
            end
            m_prev[i] = btn[i];
        end
        if (ld) begin
            found = 1'b0;
            gid   = 0;
            for (int k = 0; k < N; k++) begin
                int idx;
`ifdef BTN_EVT_RR_ARB_EN
                idx = (m_last + 1 + k) % N;
`else
                idx = k;
`endif
                if (!found && m_pend[idx] != 4'b0000) begin
                    found = 1'b1;
                    gid   = idx;
                end
            end
            m_valid = found;
            if (found) begin
                p  = m_pend[gid];
                gt = p[0] ? 2'd0 : p[2] ? 2'd2 : p[3] ? 2'd3 : 2'd1;
                m_pend[gid][gt] = 1'b0;
                m_id   = gid[1:0];
                m_type = gt;
                m_last = gid;
                e.id   = m_id;
                e.typ  = m_type;
                exp_q.push_back(e);
            end
        end
        set_ovf = '0;
        for (int i = 0; i < N; i++) begin
            for (int t = 0; t < 4; t++) begin
                if (rs[i][t]) begin
                    if (m_pend[i][t]) set_ovf[i] = 1'b1;
                    m_pend[i][t] = 1'b1;
                end
            end
        end
        m_ovf  = (clr ? '0 : m_ovf) | set_ovf;
        m_busy = m_valid;
        for (int i = 0; i < N; i++) m_busy = m_busy | (m_pend[i] != 4'b0000);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_core or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Monitor: compares presented events against the queue head, pops on accepted transfer.
    initial begin
        forever begin
            @(negedge clk_core);
            chk("valid", 32'(evt_valid), 32'(m_valid));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("ovf", 32'(ovf), 32'(m_ovf));
            if (evt_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL evt_unexpected: got id=%0d type=%0d expected no event at %0t",
                             evt_id, evt_type, $time);
                end else begin
                    chk("evt_id", 32'(evt_id), 32'(exp_q[0].id));
                    chk("evt_type", 32'(evt_type), 32'(exp_q[0].typ));
                    if (ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_core);
            #2;
        end
    endtask

    initial begin
        int stall;
        stall = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_id", 32'(evt_id), 32'd0);
        chk("rst_type", 32'(evt_type), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        // Short press, long hold with repeats, simultaneous presses.
        btn = 4'b0001; cyc(3);  btn = 4'b0000; cyc(10);
        btn = 4'b0010; cyc(20); btn = 4'b0000; cyc(10);
        btn = 4'b0101; cyc(3);  btn = 4'b0000; cyc(10);

        // Stalled channel: second release on button 3 is coalesced and flagged.
        ready = 1'b0;
        btn = 4'b1000; cyc(2); btn = 4'b0000; cyc(2);
        btn = 4'b1000; cyc(2); btn = 4'b0000; cyc(3);
        chk("stall_ovf3", 32'(ovf[3]), 32'd1);
        chk("stall_id", 32'(evt_id), 32'd3);
        chk("stall_type", 32'(evt_type), 32'd0);
        ready = 1'b1; cyc(6);
        clr = 1'b1; cyc(1); clr = 1'b0;
        chk("ovf_clear", 32'(ovf), 32'd0);
        cyc(2);

        // All four pressed together.
        btn = 4'b1111; cyc(3); btn = 4'b0000; cyc(12);

        // Asynchronous reset during a stalled transfer with button 0 held.
        ready = 1'b0; btn = 4'b0001; cyc(3);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(evt_valid), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        cyc(2);
        rst_n = 1'b1; ready = 1'b1;
        cyc(1);
        chk("post_rst_edge1_valid", 32'(evt_valid), 32'd0);
        cyc(1);
        chk("post_rst_edge2_valid", 32'(evt_valid), 32'd1);
        chk("post_rst_id", 32'(evt_id), 32'd0);
        chk("post_rst_type", 32'(evt_type), 32'd0);
        btn = 4'b0000; cyc(6);

        // Randomized buttons, backpressure, clears and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 15) == 0) btn[i] = ~btn[i];
            if (stall > 0) begin
                ready = 1'b0;
                stall--;
            end else begin
                ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 63) == 0) stall = $urandom_range(5, 30);
            end
            clr = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                cyc(1);
                rst_n = 1'b1;
            end
            cyc(1);
        end

        btn = '0; ready = 1'b1; clr = 1'b0;
        cyc(40);
        chk("drain_busy", 32'(busy), 32'd0);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
